// File: rtl/key_entry_if.sv
// Key-event, live-entry and commit handshake bundle between the keypad
// sequencer (slave) and its surroundings (master: scanner + consumer).
interface key_entry_if #(
    parameter int DIGITS = 4
) ();
    logic                  key_flag;
    logic [3:0]            key_data;
    logic                  out_ack;
    logic [4*DIGITS-1:0]   entry_bcd;
    logic [3:0]            entry_len;
    logic                  out_valid;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [3:0]            out_len;
    logic                  err;
    logic                  timeout;

    modport master (
        output key_flag, key_data, out_ack,
        input  entry_bcd, entry_len, out_valid, out_bcd, out_len, err, timeout
    );

    modport slave (
        input  key_flag, key_data, out_ack,
        output entry_bcd, entry_len, out_valid, out_bcd, out_len, err, timeout
    );
endinterface

// File: rtl/key_entry_ctrl.sv
// Keypad entry sequencer: builds a right-aligned BCD entry from key events,
// handles backspace/clear/enter, inactivity timeout and a valid/ack commit.
module key_entry_ctrl #(
    parameter int DIGITS     = 4,
    parameter int T1MS       = 50_000,
    parameter int TIMEOUT_MS = 5000
) (
    input logic       clk,
    input logic       rst_n,
    key_entry_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int PW = (T1MS > 1) ? $clog2(T1MS) : 1;

    typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;

    state_t          state, state_nx;
    logic [BW-1:0]   entry_bcd, entry_bcd_nx;
    logic [BW-1:0]   out_bcd, out_bcd_nx;
    logic [3:0]      entry_len, entry_len_nx;
    logic [3:0]      out_len, out_len_nx;
    logic            out_valid, out_valid_nx;
    logic            err, err_nx;
    logic            timeout, timeout_nx;
    logic [15:0]     idle_cnt, idle_cnt_nx;
    logic [PW-1:0]   presc;
    logic            tick;

    assign tick = (presc == PW'(T1MS - 1));

    // Free-running ms prescaler, deliberately not re-phased by key events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (tick)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            entry_bcd <= '0;
            entry_len <= '0;
            out_bcd   <= '0;
            out_len   <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            timeout   <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_nx;
            entry_bcd <= entry_bcd_nx;
            entry_len <= entry_len_nx;
            out_bcd   <= out_bcd_nx;
            out_len   <= out_len_nx;
            out_valid <= out_valid_nx;
            err       <= err_nx;
            timeout   <= timeout_nx;
            idle_cnt  <= idle_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        entry_bcd_nx = entry_bcd;
        entry_len_nx = entry_len;
        out_bcd_nx   = out_bcd;
        out_len_nx   = out_len;
        out_valid_nx = out_valid;
        err_nx       = 1'b0;
        timeout_nx   = 1'b0;
        idle_cnt_nx  = idle_cnt;

        case (state)
            IDLE, ENTRY: begin
                if (bus.key_flag) begin
                    // Any key, even an ignored one, restarts the inactivity window.
                    idle_cnt_nx = '0;
                    if (bus.key_data <= 4'd9) begin
                        if (entry_len < 4'(DIGITS)) begin
                            entry_bcd_nx = (entry_bcd << 4) | BW'(bus.key_data);
                            entry_len_nx = entry_len + 4'd1;
                            state_nx     = ENTRY;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end else begin
                        case (bus.key_data)
                            4'hA: begin
                                if (state == ENTRY) begin
                                    entry_bcd_nx = entry_bcd >> 4;
                                    entry_len_nx = entry_len - 4'd1;
                                    if (entry_len == 4'd1)
                                        state_nx = IDLE;
                                end else begin
                                    err_nx = 1'b1;
                                end
                            end
                            4'hB: begin
                                entry_bcd_nx = '0;
                                entry_len_nx = '0;
                                state_nx     = IDLE;
                            end
                            4'hF: begin
                                if (state == ENTRY) begin
                                    out_bcd_nx   = entry_bcd;
                                    out_len_nx   = entry_len;
                                    out_valid_nx = 1'b1;
                                    entry_bcd_nx = '0;
                                    entry_len_nx = '0;
                                    state_nx     = HOLD;
                                end else begin
                                    err_nx = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (state == ENTRY && tick) begin
                    if (idle_cnt == 16'(TIMEOUT_MS - 1)) begin
                        entry_bcd_nx = '0;
                        entry_len_nx = '0;
                        timeout_nx   = 1'b1;
                        idle_cnt_nx  = '0;
                        state_nx     = IDLE;
                    end else begin
                        idle_cnt_nx = idle_cnt + 16'd1;
                    end
                end
            end
            HOLD: begin
                // Keys are swallowed here, including one coinciding with the ack.
                idle_cnt_nx = '0;
                if (bus.out_ack) begin
                    out_valid_nx = 1'b0;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.entry_bcd = entry_bcd;
    assign bus.entry_len = entry_len;
    assign bus.out_bcd   = out_bcd;
    assign bus.out_len   = out_len;
    assign bus.out_valid = out_valid;
    assign bus.err       = err;
    assign bus.timeout   = timeout;
endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl (DIGITS=4, T1MS=10, TIMEOUT_MS=3) with a
// queue of expected output snapshots consumed as each step completes.
module tb_key_entry_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    key_entry_if #(.DIGITS(4)) bus ();

    key_entry_ctrl #(
        .DIGITS    (4),
        .T1MS      (10),
        .TIMEOUT_MS(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] bcd;
        logic [3:0]  len;
        logic        err;
        logic        ov;
        logic [15:0] ob;
        logic [3:0]  ol;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input string tag, input logic [15:0] bcd, input logic [3:0] len,
                            input logic e, input logic ov, input logic [15:0] ob,
                            input logic [3:0] ol, input logic to);
        exp_t x;
        x.tag = tag; x.bcd = bcd; x.len = len; x.err = e;
        x.ov = ov; x.ob = ob; x.ol = ol; x.to = to;
        sb.push_back(x);
    endtask

    task automatic exp_pop();
        exp_t x;
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            chk({x.tag, ".entry_bcd"}, 32'(bus.entry_bcd), 32'(x.bcd));
            chk({x.tag, ".entry_len"}, 32'(bus.entry_len), 32'(x.len));
            chk({x.tag, ".err"},       32'(bus.err),       32'(x.err));
            chk({x.tag, ".out_valid"}, 32'(bus.out_valid), 32'(x.ov));
            chk({x.tag, ".out_bcd"},   32'(bus.out_bcd),   32'(x.ob));
            chk({x.tag, ".out_len"},   32'(bus.out_len),   32'(x.ol));
            chk({x.tag, ".timeout"},   32'(bus.timeout),   32'(x.to));
        end
    endtask

    task automatic step(input logic kf, input logic [3:0] kd, input logic ack);
        bus.key_flag = kf;
        bus.key_data = kd;
        bus.out_ack  = ack;
        @(posedge clk);
        #1;
        bus.key_flag = 1'b0;
        bus.key_data = 4'h0;
        bus.out_ack  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int to_cnt;
        int lat;
        bit seen;

        bus.key_flag = 1'b0;
        bus.key_data = 4'h0;
        bus.out_ack  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        exp_push("reset", 16'h0, 4'd0, 0, 0, 16'h0, 4'd0, 0);
        exp_pop();
        rst_n = 1'b1;

        // Basic entry 1,2,3,F and delayed ack
        exp_push("k1", 16'h0001, 4'd1, 0, 0, 16'h0, 4'd0, 0); step(1, 4'h1, 0); exp_pop();
        exp_push("k2", 16'h0012, 4'd2, 0, 0, 16'h0, 4'd0, 0); step(1, 4'h2, 0); exp_pop();
        exp_push("k3", 16'h0123, 4'd3, 0, 0, 16'h0, 4'd0, 0); step(1, 4'h3, 0); exp_pop();
        exp_push("enter", 16'h0, 4'd0, 0, 1, 16'h0123, 4'd3, 0); step(1, 4'hF, 0); exp_pop();
        repeat (9) step(0, 4'h0, 0);
        exp_push("hold10", 16'h0, 4'd0, 0, 1, 16'h0123, 4'd3, 0); step(0, 4'h0, 0); exp_pop();
        exp_push("ack", 16'h0, 4'd0, 0, 0, 16'h0123, 4'd3, 0); step(0, 4'h0, 1); exp_pop();

        // Overflow and editing
        exp_push("k9", 16'h0009, 4'd1, 0, 0, 16'h0123, 4'd3, 0); step(1, 4'h9, 0); exp_pop();
        exp_push("k8", 16'h0098, 4'd2, 0, 0, 16'h0123, 4'd3, 0); step(1, 4'h8, 0); exp_pop();
        exp_push("k7", 16'h0987, 4'd3, 0, 0, 16'h0123, 4'd3, 0); step(1, 4'h7, 0); exp_pop();
        exp_push("k6", 16'h9876, 4'd4, 0, 0, 16'h0123, 4'd3, 0); step(1, 4'h6, 0); exp_pop();
        exp_push("k5_ovf", 16'h9876, 4'd4, 1, 0, 16'h0123, 4'd3, 0); step(1, 4'h5, 0); exp_pop();
        exp_push("bksp", 16'h0987, 4'd3, 0, 0, 16'h0123, 4'd3, 0); step(1, 4'hA, 0); exp_pop();
        exp_push("clear", 16'h0, 4'd0, 0, 0, 16'h0123, 4'd3, 0); step(1, 4'hB, 0); exp_pop();
        exp_push("bksp_idle", 16'h0, 4'd0, 1, 0, 16'h0123, 4'd3, 0); step(1, 4'hA, 0); exp_pop();
        exp_push("err_1cyc", 16'h0, 4'd0, 0, 0, 16'h0123, 4'd3, 0); step(0, 4'h0, 0); exp_pop();
        exp_push("clear_idle", 16'h0, 4'd0, 0, 0, 16'h0123, 4'd3, 0); step(1, 4'hB, 0); exp_pop();

        // Enter in IDLE, unused key, commit of a single digit
        exp_push("enter_idle", 16'h0, 4'd0, 1, 0, 16'h0123, 4'd3, 0); step(1, 4'hF, 0); exp_pop();
        exp_push("k4", 16'h0004, 4'd1, 0, 0, 16'h0123, 4'd3, 0); step(1, 4'h4, 0); exp_pop();
        exp_push("kC", 16'h0004, 4'd1, 0, 0, 16'h0123, 4'd3, 0); step(1, 4'hC, 0); exp_pop();
        exp_push("enter4", 16'h0, 4'd0, 0, 1, 16'h0004, 4'd1, 0); step(1, 4'hF, 0); exp_pop();
        exp_push("ack4", 16'h0, 4'd0, 0, 0, 16'h0004, 4'd1, 0); step(0, 4'h0, 1); exp_pop();

        // Keys dropped in HOLD, including the ack cycle
        exp_push("k4b", 16'h0004, 4'd1, 0, 0, 16'h0004, 4'd1, 0); step(1, 4'h4, 0); exp_pop();
        exp_push("k2b", 16'h0042, 4'd2, 0, 0, 16'h0004, 4'd1, 0); step(1, 4'h2, 0); exp_pop();
        exp_push("enter42", 16'h0, 4'd0, 0, 1, 16'h0042, 4'd2, 0); step(1, 4'hF, 0); exp_pop();
        exp_push("hold_k7a", 16'h0, 4'd0, 0, 1, 16'h0042, 4'd2, 0); step(1, 4'h7, 0); exp_pop();
        exp_push("hold_k7b", 16'h0, 4'd0, 0, 1, 16'h0042, 4'd2, 0); step(1, 4'h7, 0); exp_pop();
        exp_push("ack_k7", 16'h0, 4'd0, 0, 0, 16'h0042, 4'd2, 0); step(1, 4'h7, 1); exp_pop();
        exp_push("k7_after", 16'h0007, 4'd1, 0, 0, 16'h0042, 4'd2, 0); step(1, 4'h7, 0); exp_pop();
        exp_push("ack_ignored", 16'h0007, 4'd1, 0, 0, 16'h0042, 4'd2, 0); step(0, 4'h0, 1); exp_pop();
        exp_push("clear2", 16'h0, 4'd0, 0, 0, 16'h0042, 4'd2, 0); step(1, 4'hB, 0); exp_pop();

        // Inactivity timeout
        exp_push("k5_to", 16'h0005, 4'd1, 0, 0, 16'h0042, 4'd2, 0); step(1, 4'h5, 0); exp_pop();
        seen = 0;
        lat = 0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            step(0, 4'h0, 0);
            if (bus.timeout === 1'b1) begin
                seen = 1;
                lat = i;
            end
        end
        chk("timeout_seen", 32'(seen), 32'd1);
        chk("timeout_latency_window", 32'(lat >= 20 && lat <= 31), 32'd1);
        exp_push("to_pulse", 16'h0, 4'd0, 0, 0, 16'h0042, 4'd2, 1); exp_pop();
        exp_push("to_1cyc", 16'h0, 4'd0, 0, 0, 16'h0042, 4'd2, 0); step(0, 4'h0, 0); exp_pop();
        exp_push("to_idle", 16'h0, 4'd0, 1, 0, 16'h0042, 4'd2, 0); step(1, 4'hA, 0); exp_pop();

        // Keys every 20 cycles keep the entry alive
        exp_push("k1_keep", 16'h0001, 4'd1, 0, 0, 16'h0042, 4'd2, 0); step(1, 4'h1, 0); exp_pop();
        to_cnt = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 19; c++) begin
                step(0, 4'h0, 0);
                if (bus.timeout === 1'b1) to_cnt++;
            end
            step(1, 4'hD, 0);
            if (bus.timeout === 1'b1) to_cnt++;
        end
        chk("no_timeout_count", 32'(to_cnt), 32'd0);
        exp_push("keep_entry", 16'h0001, 4'd1, 0, 0, 16'h0042, 4'd2, 0); exp_pop();
        exp_push("clear3", 16'h0, 4'd0, 0, 0, 16'h0042, 4'd2, 0); step(1, 4'hB, 0); exp_pop();

        // Async reset mid-entry
        exp_push("k3r", 16'h0003, 4'd1, 0, 0, 16'h0042, 4'd2, 0); step(1, 4'h3, 0); exp_pop();
        exp_push("k4r", 16'h0034, 4'd2, 0, 0, 16'h0042, 4'd2, 0); step(1, 4'h4, 0); exp_pop();
        #2;
        rst_n = 1'b0;
        #1;
        exp_push("rst_entry", 16'h0, 4'd0, 0, 0, 16'h0, 4'd0, 0); exp_pop();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Async reset in HOLD
        exp_push("k5h", 16'h0005, 4'd1, 0, 0, 16'h0, 4'd0, 0); step(1, 4'h5, 0); exp_pop();
        exp_push("enter5", 16'h0, 4'd0, 0, 1, 16'h0005, 4'd1, 0); step(1, 4'hF, 0); exp_pop();
        #2;
        rst_n = 1'b0;
        #1;
        exp_push("rst_hold", 16'h0, 4'd0, 0, 0, 16'h0, 4'd0, 0); exp_pop();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fresh entry after reset
        exp_push("k8p", 16'h0008, 4'd1, 0, 0, 16'h0, 4'd0, 0); step(1, 4'h8, 0); exp_pop();
        exp_push("enter8", 16'h0, 4'd0, 0, 1, 16'h0008, 4'd1, 0); step(1, 4'hF, 0); exp_pop();
        exp_push("ack8", 16'h0, 4'd0, 0, 0, 16'h0008, 4'd1, 0); step(0, 4'h0, 1); exp_pop();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
